// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner sequencing for one shared bus slave port.
// Each master request is granted, launched on the shared bus and held until
// the slave completes it. Address decode stays in the downstream decoder.
// Optional feature: define BUS_ARBITER_TIMEOUT_EN to abort a BUSY transaction
// with m_err after TimeoutCycles cycles without s_ready.
module bus_arbiter #(
  parameter int NumMasters    = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NumMasters-1:0]           m_valid,
  input  logic [NumMasters*AddrWidth-1:0] m_addr,
  input  logic [NumMasters-1:0]           m_we,
  input  logic [NumMasters*DataWidth-1:0] m_wdata,
  output logic [NumMasters-1:0]           m_ready,
  output logic [DataWidth-1:0]            m_rdata,
  output logic                            m_err,
  output logic [NumMasters-1:0]           grant,
  output logic                            s_valid,
  output logic [AddrWidth-1:0]            s_addr,
  output logic                            s_we,
  output logic [DataWidth-1:0]            s_wdata,
  input  logic                            s_ready,
  input  logic [DataWidth-1:0]            s_rdata
);

  localparam int IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;
  // One extra bit so (last + offset) never overflows before the wrap.
  localparam int SumW = IdxW + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // After reset the pointer sits on the highest master so master 0 wins first.
  localparam logic [IdxW-1:0] LastInit = IdxW'(NumMasters - 1);

  if (NumMasters < 2 || NumMasters > 8 || TimeoutCycles < 1 || TimeoutCycles > 65535)
  begin : g_param_check
    $error("bus_arbiter: parameter out of range");
  end

  logic [0:0]           state_r;
  logic [IdxW-1:0]      last_r;
  logic [IdxW-1:0]      owner_r;

  logic                 found_s;
  logic                 hit_s;
  logic [IdxW-1:0]      winner_s;
  logic [SumW-1:0]      cand_s;
  logic [IdxW-1:0]      cand_idx_s;

  logic [NumMasters-1:0] sel_grant_s;
  logic [AddrWidth-1:0]  sel_addr_s;
  logic                  sel_we_s;
  logic [DataWidth-1:0]  sel_wdata_s;

  logic                 done_s;
  logic                 abort_s;
  logic                 finish_s;

  // Round-robin scan: first requester from (last+1) upward, wrapping at NumMasters-1.
  always_comb begin
    found_s    = 1'b0;
    hit_s      = 1'b0;
    winner_s   = '0;
    cand_s     = '0;
    cand_idx_s = '0;
    for (int k = 0; k < NumMasters; k++) begin
      cand_s = {1'b0, last_r} + SumW'(k + 1);
      cand_s = (cand_s >= SumW'(NumMasters)) ? (cand_s - SumW'(NumMasters)) : cand_s;
      cand_idx_s = cand_s[IdxW-1:0];
      hit_s      = !found_s && m_valid[cand_idx_s];
      winner_s   = hit_s ? cand_idx_s : winner_s;
      found_s    = found_s | hit_s;
    end
  end

  // Mux the winning master's request fields and one-hot grant.
  always_comb begin
    sel_grant_s = '0;
    sel_addr_s  = '0;
    sel_we_s    = 1'b0;
    sel_wdata_s = '0;
    for (int k = 0; k < NumMasters; k++) begin
      sel_grant_s[k] = (winner_s == IdxW'(k));
      sel_addr_s     = (winner_s == IdxW'(k)) ? m_addr[k*AddrWidth +: AddrWidth] : sel_addr_s;
      sel_we_s       = (winner_s == IdxW'(k)) ? m_we[k] : sel_we_s;
      sel_wdata_s    = (winner_s == IdxW'(k)) ? m_wdata[k*DataWidth +: DataWidth] : sel_wdata_s;
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles);

  logic [15:0] wait_cnt_r;

  // Count BUSY cycles without s_ready; held at zero while IDLE so each entry starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 16'd0;
    end else if (state_r == IDLE) begin
      wait_cnt_r <= 16'd0;
    end else if (!s_ready && (wait_cnt_r != 16'hFFFF)) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Watchdog abort; a same-cycle s_ready takes precedence as a normal completion.
  always_comb begin
    abort_s = (state_r == BUSY) && !s_ready && (wait_cnt_r == TimeoutLimit);
  end
`else
  // Without the watchdog BUSY waits indefinitely for the slave.
  always_comb begin
    abort_s = 1'b0;
  end
`endif

  // Completion qualifiers: slave handshake only counts while BUSY.
  always_comb begin
    done_s   = (state_r == BUSY) && s_ready;
    finish_s = done_s | abort_s;
  end

  // Same-cycle master response: pulse to the owner only, data gated to zero otherwise.
  always_comb begin
    m_ready = finish_s ? grant : '0;
    m_rdata = done_s ? s_rdata : '0;
    m_err   = abort_s;
  end

  // Ownership FSM: grant and latch in IDLE, hold the bus until completion in BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      last_r  <= LastInit;
      owner_r <= '0;
      grant   <= '0;
      s_valid <= 1'b0;
      s_addr  <= '0;
      s_we    <= 1'b0;
      s_wdata <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r <= BUSY;
            owner_r <= winner_s;
            grant   <= sel_grant_s;
            s_valid <= 1'b1;
            s_addr  <= sel_addr_s;
            s_we    <= sel_we_s;
            s_wdata <= sel_wdata_s;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (finish_s) begin
            state_r <= IDLE;
            last_r  <= owner_r;
            grant   <= '0;
            s_valid <= 1'b0;
            s_addr  <= '0;
            s_we    <= 1'b0;
            s_wdata <= '0;
          end else begin
            state_r <= BUSY;
          end
        end
        default: begin
          state_r <= IDLE;
          grant   <= '0;
          s_valid <= 1'b0;
          s_addr  <= '0;
          s_we    <= 1'b0;
          s_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that shares one system bus slave port between NumMasters requesters, such as CPU instruction fetch, CPU data and DMA.
- Each transaction is granted, launched on the shared bus and held until the slave side completes it.
- Downstream address decode and masking stay in the existing decoder. This block sequences only ownership and the handshake.

Parameters:
- NumMasters, 2, number of requesters (2..8).
- AddrWidth, 32, address width.
- DataWidth, 32, data width.
- TimeoutCycles, 255, cycles in BUSY before abort. Used only with the optional feature. Range 1..65535.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- m_valid  input  NumMasters  per-master request. Held high until the matching m_ready.
- m_addr  input  NumMasters*AddrWidth  packed addresses; master i at [i*AddrWidth +: AddrWidth].
- m_we  input  NumMasters  write enable per master.
- m_wdata  input  NumMasters*DataWidth  packed write data.
- m_ready  output  NumMasters  one-cycle completion pulse to the granted master.
- m_rdata  output  DataWidth  read data, shared by all masters. Valid only while the master's m_ready bit is high.
- m_err  output  1  error flag, qualified by m_ready.
- grant  output  NumMasters  one-hot current owner. All zero when IDLE.
- s_valid  output  1  shared bus request.
- s_addr  output  AddrWidth  shared bus address.
- s_we  output  1  shared bus write enable.
- s_wdata  output  DataWidth  shared bus write data.
- s_ready  input  1  slave completion. Single-cycle, only meaningful while s_valid.
- s_rdata  input  DataWidth  slave read data, valid with s_ready.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, grant = 0, s_valid = 0.
  - s_addr, s_wdata and s_we all 0.
  - m_ready = 0, m_err = 0, m_rdata = 0.
  - last = NumMasters-1, so master 0 has first priority.
- FSM states: IDLE, BUSY.
- IDLE:
  - If any m_valid, select the first requester scanning from (last+1) mod NumMasters upward with wrap.
  - Register grant one-hot to the winner.
  - Latch that master's addr, we and wdata into s_addr, s_we and s_wdata.
  - Set s_valid and move to BUSY.
  - With no request, stay in IDLE with all outputs idle.
- BUSY:
  - s_valid = 1. s_addr, s_we and s_wdata stay stable from the latched values; later master input changes are ignored.
  - When s_ready = 1, combinationally in the same cycle:
    - m_ready[g] = 1 and m_rdata = s_rdata for the granted master g.
    - m_err = 0.
  - On the next edge: state goes to IDLE, last = g, grant = 0, s_valid = 0.
- Latency:
  - Request seen at edge N gives s_valid high from edge N+1.
  - Minimum 2 cycles from m_valid to m_ready, with a zero-wait slave.
  - One mandatory IDLE cycle between consecutive transactions.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N-1,0. No master waits more than NumMasters-1 transactions.
- m_ready and m_rdata outputs:
  - m_ready is never asserted to a non-granted master.
  - m_rdata = 0 whenever no m_ready bit is high.
- Masters deasserting m_valid while granted is a protocol violation. The transaction still completes and the m_ready pulse is still generated.
- s_ready while IDLE is ignored.
- Async reset mid-BUSY aborts the transaction immediately. No m_ready is issued.
- Non-power-of-two NumMasters: the rotation pointer wraps at NumMasters-1, never at 2^k-1.

Optional Feature:
- Macro: BUS_ARBITER_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle with s_ready = 0.
  - When it reaches TimeoutCycles without s_ready, issue m_ready[g] = 1, m_err = 1 and m_rdata = 0 that cycle.
  - Drop s_valid and return to IDLE on the next edge, with last = g.
  - s_ready in the same cycle as the timeout wins: normal completion, m_err = 0.
- Not defined: no counter, and m_err is tied 0. BUSY waits indefinitely for s_ready.

Test Plan:
- Reset, then m_valid = 2'b01, addr 0x1000_0004, we = 1, wdata 0xDEADBEEF, slave ready after 3 cycles -> s_valid with latched values from edge +1, m_ready[0] single pulse, grant 2'b01 then 0.
- Both masters request continuously for 6 transactions, zero-wait slave -> grant order 0,1,0,1,0,1, each m_ready 2 cycles apart + 1 idle cycle.
- NumMasters = 3, masters 0 and 2 requesting, last = 0 -> master 2 wins. Next grant is master 0.
- Read, master 1, s_rdata 0x12345678 with s_ready -> m_rdata = 0x12345678 only while m_ready[1]. m_rdata = 0 on the following cycle.
- rst_n pulsed low mid-BUSY -> all outputs 0 immediately, no m_ready. After release, master 0 has priority.
- With BUS_ARBITER_TIMEOUT_EN and TimeoutCycles = 4, slave never ready -> m_ready pulse with m_err = 1, rdata 0. Variant with s_ready on the timeout cycle -> m_err = 0.
